// File: rtl/clock_period_meter.sv
// Measures the half-period of a slow toggling input in clk cycles and reports it
// as an equivalent divider setting (half-period - 1), with lock and timeout flags.
module clock_period_meter #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOLERANCE   = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] divisor_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      MW         = $clog2(LOCK_COUNT);
  localparam logic [WIDTH-1:0] MAX        = '1;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOL        = WIDTH'(TOLERANCE);
  localparam logic [MW-1:0]    MATCH_LOCK = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev_sync, sig_edge;
  logic [WIDTH-1:0]       cnt, cnt_next, div_next, meas, diff;
  logic [MW-1:0]          match_cnt, match_next;
  logic                   have_meas, have_next, valid_next, locked_next, timeout_next, agree;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync      <= '0;
      prev_sync <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], sig_in};
      prev_sync <= sync[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync[SYNC_STAGES-1] ^ prev_sync;

  // Agreement is judged against the previously reported divisor.
  always_comb begin
    meas  = cnt - ONE;
    diff  = (meas > divisor_out) ? (meas - divisor_out) : (divisor_out - meas);
    agree = (diff <= TOL);
  end

  always_comb begin
    state_next   = state;
    cnt_next     = (cnt == MAX) ? cnt : cnt + ONE;
    match_next   = match_cnt;
    div_next     = divisor_out;
    valid_next   = 1'b0;
    locked_next  = locked;
    timeout_next = timeout;
    have_next    = have_meas;
    if (clear) begin
      state_next   = IDLE;
      cnt_next     = '0;
      match_next   = '0;
      locked_next  = 1'b0;
      timeout_next = 1'b0;
      have_next    = 1'b0;
    end else if (sig_edge) begin
      cnt_next     = ONE;
      timeout_next = 1'b0;
      case (state)
        IDLE: begin
          state_next = MEAS;
          match_next = '0;
          have_next  = 1'b0;
        end
        MEAS: begin
          div_next   = meas;
          valid_next = 1'b1;
          have_next  = 1'b1;
          if (agree && have_meas) begin
            match_next = match_cnt + MW'(1);
            if (match_cnt + MW'(1) == MATCH_LOCK) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
            end
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          div_next   = meas;
          valid_next = 1'b1;
          have_next  = 1'b1;
          if (!agree) begin
            state_next  = MEAS;
            match_next  = '0;
            locked_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (cnt == MAX - ONE) begin
      cnt_next     = MAX;
      timeout_next = 1'b1;
      state_next   = IDLE;
      locked_next  = 1'b0;
      match_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      match_cnt   <= '0;
      have_meas   <= 1'b0;
      divisor_out <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      match_cnt   <= match_next;
      have_meas   <= have_next;
      divisor_out <= div_next;
      meas_valid  <= valid_next;
      locked      <= locked_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: lock, mismatch, fast toggling, timeout,
// reset/clear behaviour and tolerance, with hand-computed expectations.
module tb_clock_period_meter;

  logic       clk = 1'b0;
  logic       resetn, sig, clear, sig_t, clear_t;
  logic [7:0] divisor, divisor_t;
  logic       meas_valid, locked, timeout;
  logic       meas_valid_t, locked_t, timeout_t;
  int         errors = 0;
  int         checks = 0;

  clock_period_meter #(.WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOLERANCE(0)) dut (
    .clk(clk), .resetn(resetn), .sig_in(sig), .clear(clear),
    .divisor_out(divisor), .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  clock_period_meter #(.WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOLERANCE(1)) dut_tol (
    .clk(clk), .resetn(resetn), .sig_in(sig_t), .clear(clear_t),
    .divisor_out(divisor_t), .meas_valid(meas_valid_t), .locked(locked_t), .timeout(timeout_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; sig = 1'b0; sig_t = 1'b0; clear = 1'b0; clear_t = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; sig = 1'b0; sig_t = 1'b0; clear = 1'b0; clear_t = 1'b0;
    repeat (3) tick();
    checks += 4;
    if (divisor !== 8'd0) begin errors++; $display("FAIL reset_div got=%0d exp=0", divisor); end
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    resetn = 1'b1;
    repeat (2) tick();
    checks += 3;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", meas_valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked got=%b exp=0", locked); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL idle_timeout got=%b exp=0", timeout); end
  endtask

  // half-period 10: arming toggle at 0, measurements at 12,22,32,42
  task automatic test_lock();
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) sig = ~sig;
      tick();
      checks += 2;
      if (meas_valid !== (i >= 12 && (i - 12) % 10 == 0)) begin
        errors++; $display("FAIL lock_valid i=%0d got=%b", i, meas_valid);
      end
      if (locked !== (i >= 42)) begin
        errors++; $display("FAIL lock_locked i=%0d got=%b exp=%b", i, locked, i >= 42);
      end
      if (meas_valid === 1'b1) begin
        checks++;
        if (divisor !== 8'd9) begin errors++; $display("FAIL lock_div i=%0d got=%0d exp=9", i, divisor); end
      end
    end
  endtask

  // toggles at 0,13,23,33,43,53 continuing the 10-cycle rhythm
  task automatic test_mismatch();
    for (int j = 0; j < 58; j++) begin
      logic exp_v;
      if (j == 0 || (j >= 13 && (j - 13) % 10 == 0)) sig = ~sig;
      tick();
      exp_v = (j == 2) || (j >= 15 && (j - 15) % 10 == 0);
      checks += 2;
      if (meas_valid !== exp_v) begin
        errors++; $display("FAIL mis_valid j=%0d got=%b exp=%b", j, meas_valid, exp_v);
      end
      if (locked !== (j < 15 || j >= 55)) begin
        errors++; $display("FAIL mis_locked j=%0d got=%b", j, locked);
      end
      if (exp_v) begin
        checks++;
        if (divisor !== ((j == 15) ? 8'd12 : 8'd9)) begin
          errors++; $display("FAIL mis_div j=%0d got=%0d exp=%0d", j, divisor, (j == 15) ? 12 : 9);
        end
      end
    end
  endtask

  // last measurement two cycles ago; timeout lands 254 cycles after it
  task automatic test_timeout();
    for (int k = 1; k <= 262; k++) begin
      tick();
      checks += 4;
      if (meas_valid !== 1'b0) begin errors++; $display("FAIL to_valid k=%0d got=%b exp=0", k, meas_valid); end
      if (timeout !== (k >= 252)) begin errors++; $display("FAIL to_timeout k=%0d got=%b", k, timeout); end
      if (locked !== (k < 252)) begin errors++; $display("FAIL to_locked k=%0d got=%b", k, locked); end
      if (divisor !== 8'd9) begin errors++; $display("FAIL to_div k=%0d got=%0d exp=9", k, divisor); end
    end
    for (int m = 0; m < 13; m++) begin
      if (m == 0 || m == 7) sig = ~sig;
      tick();
      checks += 4;
      if (timeout !== (m < 2)) begin errors++; $display("FAIL rearm_timeout m=%0d got=%b", m, timeout); end
      if (meas_valid !== (m == 9)) begin errors++; $display("FAIL rearm_valid m=%0d got=%b", m, meas_valid); end
      if (locked !== 1'b0) begin errors++; $display("FAIL rearm_locked m=%0d got=%b exp=0", m, locked); end
      if (divisor !== ((m >= 9) ? 8'd6 : 8'd9)) begin
        errors++; $display("FAIL rearm_div m=%0d got=%0d exp=%0d", m, divisor, (m >= 9) ? 6 : 9);
      end
    end
  endtask

  task automatic test_every_clk();
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      sig = ~sig;
      tick();
      checks += 3;
      if (meas_valid !== (i >= 3)) begin errors++; $display("FAIL fast_valid i=%0d got=%b", i, meas_valid); end
      if (locked !== (i >= 6)) begin errors++; $display("FAIL fast_locked i=%0d got=%b", i, locked); end
      if (divisor !== 8'd0) begin errors++; $display("FAIL fast_div i=%0d got=%0d exp=0", i, divisor); end
    end
  endtask

  task automatic test_async_reset();
    repeat (2) begin sig = ~sig; tick(); end
    #3;
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL pre_rst_locked got=%b exp=1", locked); end
    if (meas_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", meas_valid); end
    resetn = 1'b0;
    #1;
    checks += 4;
    if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got=%b exp=0", locked); end
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", meas_valid); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL arst_timeout got=%b exp=0", timeout); end
    if (divisor !== 8'd0) begin errors++; $display("FAIL arst_div got=%0d exp=0", divisor); end
    sig = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  // lock on fast toggles, then clear lands on the edge of the toggle at 12
  task automatic test_clear();
    for (int i = 0; i < 31; i++) begin
      if (i <= 7 || i == 12 || i == 20 || i == 26) sig = ~sig;
      clear = (i == 14);
      tick();
      clear = 1'b0;
      checks += 3;
      if (meas_valid !== ((i >= 3 && i <= 9) || i == 28)) begin
        errors++; $display("FAIL clr_valid i=%0d got=%b", i, meas_valid);
      end
      if (locked !== (i >= 6 && i <= 13)) begin errors++; $display("FAIL clr_locked i=%0d got=%b", i, locked); end
      if (divisor !== ((i >= 28) ? 8'd5 : 8'd0)) begin
        errors++; $display("FAIL clr_div i=%0d got=%0d exp=%0d", i, divisor, (i >= 28) ? 5 : 0);
      end
    end
  endtask

  // half-periods 10,11,10,11,10,11 with tolerance 1
  task automatic test_tolerance();
    int n = 0;
    for (int i = 0; i < 68; i++) begin
      logic exp_v;
      if (i == 0 || i == 10 || i == 21 || i == 31 || i == 42 || i == 52 || i == 63) sig_t = ~sig_t;
      tick();
      exp_v = (i == 12 || i == 23 || i == 33 || i == 44 || i == 54 || i == 65);
      checks += 2;
      if (meas_valid_t !== exp_v) begin errors++; $display("FAIL tol_valid i=%0d got=%b exp=%b", i, meas_valid_t, exp_v); end
      if (locked_t !== (i >= 44)) begin errors++; $display("FAIL tol_locked i=%0d got=%b", i, locked_t); end
      if (exp_v) begin
        n++;
        checks++;
        if (divisor_t !== ((n % 2 == 1) ? 8'd9 : 8'd10)) begin
          errors++; $display("FAIL tol_div i=%0d got=%0d exp=%0d", i, divisor_t, (n % 2 == 1) ? 9 : 10);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_timeout();
    test_every_clk();
    test_async_reset();
    test_clear();
    test_tolerance();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
